// File: rtl/nmea_pkg.sv
// Shared definitions for the NMEA heading path: receiver states and parser characters.
package nmea_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int unsigned OVERSAMPLE_DEF = 16;

  localparam logic [7:0] CHAR_DOLLAR = 8'h24;
  localparam logic [7:0] CHAR_STAR   = 8'h2A;
  localparam logic [7:0] CHAR_COMMA  = 8'h2C;
  localparam logic [7:0] CHAR_CR     = 8'h0D;

endpackage

// File: rtl/baud_tick.sv
// Oversample tick generator: counts 0..i_div and pulses o_tick on the terminal count.
module baud_tick (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic [15:0] i_div,
  output logic        o_tick
);

  logic [15:0] cnt;

  assign o_tick = !i_clear && (cnt == i_div);

  // Divider counter; held at 0 while cleared so the first tick lands i_div+1 clocks later.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (i_clear || o_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/nmea_uart_rx.sv
// 8N1 UART receiver feeding the NMEA parser with single-cycle write strobes.
module nmea_uart_rx
  import nmea_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF,  // power of two, >= 8
  parameter int unsigned SYNC_STAGES = 2                // >= 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx,
  input  logic [15:0] i_baud_div,
  input  logic        i_full,
  output logic        o_write,
  output logic [7:0]  o_char,
  output logic        o_frame_err,
  output logic        o_overrun,
  output logic [7:0]  o_err_cnt,
  output logic        o_busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  rx_state_t              state;
  logic [15:0]            div_l;
  logic [TW-1:0]          ticks;
  logic [2:0]             bits;
  logic [7:0]             shift;
  logic                   tick;

  assign rx_s   = sync[SYNC_STAGES-1];
  assign o_busy = (state != IDLE);

  // Input synchronizer; resets to the idle (high) line level.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], i_rx};
    end
  end

  // Divider is held in clear while idle so its phase restarts at start detection.
  baud_tick u_baud_tick (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (state == IDLE),
    .i_div   (div_l),
    .o_tick  (tick)
  );

  // Frame state machine with registered strobes and saturating error count.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= IDLE;
      div_l       <= '0;
      ticks       <= '0;
      bits        <= '0;
      shift       <= '0;
      o_write     <= 1'b0;
      o_char      <= '0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      o_err_cnt   <= '0;
    end else begin
      o_write     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            div_l <= i_baud_div;
            ticks <= '0;
            bits  <= '0;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (ticks == HALF_LAST) begin
              // Restart the bit phase so data samples fall mid-bit.
              ticks <= '0;
              state <= rx_s ? IDLE : DATA;
            end else begin
              ticks <= ticks + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            ticks <= ticks + 1'b1;  // wraps to 0 after FULL_LAST
            if (ticks == FULL_LAST) begin
              shift <= {rx_s, shift[7:1]};
              bits  <= bits + 3'd1;
              if (bits == 3'd7) begin
                state <= STOP;
              end
            end
          end
        end
        STOP: begin
          if (tick) begin
            ticks <= ticks + 1'b1;
            if (ticks == FULL_LAST) begin
              if (rx_s) begin
                // Leave mid stop bit so an immediately following start edge is caught.
                state <= IDLE;
                if (!i_full) begin
                  o_write <= 1'b1;
                  o_char  <= shift;
                end else begin
                  o_overrun <= 1'b1;
                  if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
                end
              end else begin
                o_frame_err <= 1'b1;
                if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
                state <= WAIT_HIGH;
              end
            end
          end
        end
        WAIT_HIGH: begin
          // A held-low (break) line must not be taken as a new start bit.
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nmea_uart_rx.sv
// Directed bench for nmea_uart_rx at i_baud_div=3 (64 clocks per bit).
module tb_nmea_uart_rx;

  localparam int BIT = 64;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_rx;
  logic [15:0] i_baud_div;
  logic        i_full;
  logic        o_write;
  logic [7:0]  o_char;
  logic        o_frame_err;
  logic        o_overrun;
  logic [7:0]  o_err_cnt;
  logic        o_busy;

  int n_checks = 0;
  int n_pass   = 0;

  int wr_cnt   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int wide     = 0;
  int overlap  = 0;
  logic prev_write = 1'b0;
  logic prev_ferr  = 1'b0;
  logic prev_ovr   = 1'b0;
  logic [7:0] chars[$];

  nmea_uart_rx dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx        (i_rx),
    .i_baud_div  (i_baud_div),
    .i_full      (i_full),
    .o_write     (o_write),
    .o_char      (o_char),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_err_cnt   (o_err_cnt),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one 8N1 frame LSB-first; stop level and length are selectable.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int stop_len);
    i_rx = 1'b0;
    repeat (BIT) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = data[i];
      repeat (BIT) @(negedge i_clk);
    end
    i_rx = stop_bit;
    repeat (stop_len) @(negedge i_clk);
    i_rx = 1'b1;
  endtask

  // Record strobes away from the active edge.
  always @(negedge i_clk) begin
    if (o_write) begin
      wr_cnt <= wr_cnt + 1;
      chars.push_back(o_char);
    end
    if (o_frame_err) ferr_cnt <= ferr_cnt + 1;
    if (o_overrun) ovr_cnt <= ovr_cnt + 1;
    if ((o_write && prev_write) || (o_frame_err && prev_ferr) || (o_overrun && prev_ovr))
      wide <= wide + 1;
    if ((32'(o_write) + 32'(o_frame_err) + 32'(o_overrun)) > 1) overlap <= overlap + 1;
    prev_write <= o_write;
    prev_ferr  <= o_frame_err;
    prev_ovr   <= o_overrun;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int wr_before;

    i_rst      = 1'b0;
    i_rx       = 1'b1;
    i_baud_div = 16'd3;
    i_full     = 1'b0;
    repeat (3) @(negedge i_clk);

    check("rst_write", 32'(o_write), 32'd0);
    check("rst_char", 32'(o_char), 32'h00);
    check("rst_ferr", 32'(o_frame_err), 32'd0);
    check("rst_ovr", 32'(o_overrun), 32'd0);
    check("rst_errcnt", 32'(o_err_cnt), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);

    i_rst = 1'b1;
    repeat (5) @(negedge i_clk);

    // '$': strobe 609 clocks after the detect cycle, which itself trails the line by 2 syncs.
    lat = 0;
    fork
      send_frame(8'h24, 1'b1, BIT);
      begin
        while (!o_write && lat < 2000) begin
          @(negedge i_clk);
          lat++;
        end
      end
    join
    repeat (10) @(negedge i_clk);
    check("dollar_wr_cnt", 32'(wr_cnt), 32'd1);
    check("dollar_char", 32'(chars[0]), 32'h24);
    check("dollar_latency", 32'(lat), 32'd611);
    check("dollar_errcnt", 32'(o_err_cnt), 32'd0);

    // "HDG" back to back with no idle gap.
    send_frame(8'h48, 1'b1, BIT);
    send_frame(8'h44, 1'b1, BIT);
    send_frame(8'h47, 1'b1, BIT);
    repeat (20) @(negedge i_clk);
    check("hdg_wr_cnt", 32'(wr_cnt), 32'd4);
    check("hdg_char_h", 32'(chars[1]), 32'h48);
    check("hdg_char_d", 32'(chars[2]), 32'h44);
    check("hdg_char_g", 32'(chars[3]), 32'h47);
    check("hdg_errcnt", 32'(o_err_cnt), 32'd0);

    // 20-clock glitch: false start, back to idle quietly.
    i_rx = 1'b0;
    repeat (20) @(negedge i_clk);
    i_rx = 1'b1;
    check("glitch_busy_high", 32'(o_busy), 32'd1);
    repeat (60) @(negedge i_clk);
    check("glitch_busy_low", 32'(o_busy), 32'd0);
    check("glitch_wr_cnt", 32'(wr_cnt), 32'd4);
    check("glitch_errcnt", 32'(o_err_cnt), 32'd0);

    // 0x55 with low stop bit and a further 200-clock break, then 0x41.
    send_frame(8'h55, 1'b0, BIT + 200);
    repeat (BIT) @(negedge i_clk);
    check("ferr_cnt", 32'(ferr_cnt), 32'd1);
    check("ferr_errcnt", 32'(o_err_cnt), 32'd1);
    check("ferr_no_write", 32'(wr_cnt), 32'd4);
    check("ferr_busy", 32'(o_busy), 32'd0);
    send_frame(8'h41, 1'b1, BIT);
    repeat (10) @(negedge i_clk);
    check("after_ferr_wr_cnt", 32'(wr_cnt), 32'd5);
    check("after_ferr_char", 32'(chars[4]), 32'h41);
    check("after_ferr_ferr", 32'(ferr_cnt), 32'd1);

    // 0x2A with the FIFO full: dropped, counted as an overrun.
    i_full = 1'b1;
    send_frame(8'h2A, 1'b1, BIT);
    repeat (10) @(negedge i_clk);
    i_full = 1'b0;
    check("ovr_cnt", 32'(ovr_cnt), 32'd1);
    check("ovr_no_write", 32'(wr_cnt), 32'd5);
    check("ovr_char_kept", 32'(o_char), 32'h41);
    check("ovr_errcnt", 32'(o_err_cnt), 32'd2);

    // Reset in the middle of data bit 4 of a partial frame.
    i_rx = 1'b0;
    repeat (BIT) @(negedge i_clk);
    for (int i = 0; i < 4; i++) begin
      i_rx = (i % 2 == 0) ? 1'b1 : 1'b0;
      repeat (BIT) @(negedge i_clk);
    end
    i_rx = 1'b1;
    repeat (BIT / 2) @(negedge i_clk);
    check("pre_rst_busy", 32'(o_busy), 32'd1);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("mid_rst_char", 32'(o_char), 32'h00);
    check("mid_rst_errcnt", 32'(o_err_cnt), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_write", 32'(o_write), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    wr_before = wr_cnt;
    repeat (12 * BIT) @(negedge i_clk);
    check("post_rst_idle", 32'(o_busy), 32'd0);
    check("post_rst_no_write", 32'(wr_cnt), 32'(wr_before));
    send_frame(8'h0D, 1'b1, BIT);
    repeat (10) @(negedge i_clk);
    check("cr_wr_cnt", 32'(wr_cnt), 32'(wr_before + 1));
    check("cr_char", 32'(chars[chars.size() - 1]), 32'h0D);
    check("cr_errcnt", 32'(o_err_cnt), 32'd0);
    check("cr_ferr", 32'(ferr_cnt), 32'd1);

    check("pulse_width", 32'(wide), 32'd0);
    check("pulse_exclusive", 32'(overlap), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
